cur_block_fetch: RTL
====================

# cur_block_fetch

Streams the current frame out of frame memory into the current-block double buffer, one 8×8 block at a time in raster order. For each block it issues 16 word reads (4 pixels per word), forwards each word with a write strobe (`read_en`), and then pulses `next_block` so the buffer swaps halves. Blocks are paced by the motion-estimation core through `consumer_ready`. It sits between the frame SRAM and the current-block buffer, on the current-frame side of the ME datapath.

## Interface

**Parameters**
- `FRAME_W`, default 64: frame width in pixels; multiple of 8, at most 2040.
- `FRAME_H`, default 64: frame height in pixels; multiple of 8, at most 2040.
- `ADDR_W`, default 10: memory word-address width; must satisfy 2^ADDR_W ≥ FRAME_W·FRAME_H/4.

**Ports**
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst_n`, in, 1: reset, **asynchronous, active-low**.
- `start`, in, 1: one-cycle pulse that starts a frame. Ignored unless the block is idle.
- `consumer_ready`, in, 1: the downstream side can accept the next block.
- `mem_addr`, out, ADDR_W: word address to the synchronous SRAM.
- `mem_rd`, out, 1: read request. Data returns on `mem_rdata` one cycle later.
- `mem_rdata`, in, 32: read data. Pixel 0 is in bits [7:0].
- `cur_data`, out, 32: word to the buffer. Registered.
- `read_en`, out, 1: `cur_data` is valid this cycle. Registered.
- `next_block`, out, 1: one-cycle pulse that tells the buffer to swap halves.
- `block_x`, out, 8: column index of the block being fetched or last fetched.
- `block_y`, out, 8: row index of the block being fetched or last fetched.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse, high in the SWAP cycle of the last block.

## Operation

**Memory layout**
- Row-major frame. WPR = FRAME_W/4 words per row.
- Word address = y·WPR + x/4.

**Word order within a block**
- Block (bx, by) is read as word k = 0..15, with r = k>>1 and h = k&1.
- Address for word k = (8·by + r)·WPR + 2·bx + h.
- The buffer therefore receives row 0 low half, row 0 high half, row 1 low half, and so on.

**State machine**
- IDLE
  - On `start`: clear bx and by to 0, go to WAIT.
- WAIT
  - `consumer_ready`=1 at the edge: go to FETCH with word counter k=0.
- FETCH
  - `mem_rd`=1 and `mem_addr` = address(k) every cycle.
  - k increments each cycle. After k=15, go to DRAIN.
  - `consumer_ready` is not sampled during FETCH.
- DRAIN
  - Two cycles with `mem_rd`=0, letting the last two words leave the pipeline. Then go to SWAP.
- SWAP
  - `next_block`=1 for one cycle.
  - If bx = FRAME_W/8−1 and by = FRAME_H/8−1: `done`=1, go to IDLE.
  - Otherwise advance to the next block and go to WAIT:
    - If bx is at its maximum: bx = 0, by = by+1.
    - Else: bx = bx+1.

**Data path**
- One pipeline register stage.
- `read_en` is `mem_rd` delayed two cycles.
- `cur_data` is `mem_rdata` registered when the delayed-by-one `mem_rd` is high. It holds its value otherwise.

**Address arithmetic**
- Use ADDR_W bits with no overflow. This follows from the ADDR_W constraint above.
- The row base (8·by + r)·WPR is updated incrementally; a multiplier is allowed but not required.

**Reset values**
- All outputs are 0: `mem_addr`, `mem_rd`, `cur_data`, `read_en`, `next_block`, `block_x`, `block_y`, `busy`, `done`.
- State = IDLE.

**Boundary conditions**
- `start` while busy: ignored, with no effect on the counters.
- `consumer_ready` low in WAIT: remain in WAIT indefinitely. All strobes stay 0.
- `rst_n` asserted mid-FETCH or mid-DRAIN: outputs clear immediately. No `next_block` is produced for the partial block.
- `start` in the same cycle that `done` is pulsed: ignored, because the state is still SWAP.
- 8×8 frame (one block): the SWAP cycle asserts `next_block` and `done` together.

## Timing

- Reference point: `start` is sampled at edge E0.
- WAIT begins after E0. With `consumer_ready` high, FETCH spans cycles c1..c16.
- `read_en` is high in c3..c18, exactly 16 consecutive cycles.
- DRAIN is c17..c18. SWAP, with `next_block`, is c19.
- The next block's FETCH starts at c21 at the earliest.
- Throughput: 19 cycles per block plus WAIT time (minimum 1 cycle).
- A 64×64 frame takes at least 64·20 − 1 = 1279 cycles from `start` to `done`.
- `read_en` is never high in the same cycle as `next_block`.

## Test plan

- **Single block.** 8×8 frame, mem[i] = i, `consumer_ready`=1, `start`.
  - `mem_addr` goes 0,1,2,…,15? No: 0,1,2,3,…,15 with WPR=2.
  - `cur_data` = 0..15 on 16 consecutive `read_en` cycles.
  - `next_block` and `done` are high together exactly 1 cycle after the last `read_en`.
- **Block addressing.** 64×64 frame, observe block (bx=3, by=2).
  - `mem_addr` sequence: 262, 263, 278, 279, …, 374, 375.
  - Formula: (16+r)·16 + 6 + h.
  - `block_x`=3 and `block_y`=2 during the fetch.
- **Full frame.** 64×64 frame, `consumer_ready` tied high.
  - Exactly 64 `next_block` pulses and 1024 `read_en` cycles.
  - `done` arrives 1279 cycles after `start`, then `busy`=0.
- **Backpressure.** Drop `consumer_ready` after block 0 for 50 cycles.
  - No `mem_rd`, `read_en` or `next_block` during the stall.
  - Block 1 starts FETCH the cycle after `consumer_ready` rises.
- **Reset mid-fetch.** Assert `rst_n`=0 at FETCH k=7.
  - All outputs go to 0 asynchronously. No `next_block`.
  - A later `start` restarts from block (0,0) at address 0.
- **Start while busy.** Pulse `start` during block 5.
  - Traversal, `block_x`/`block_y` and total pulse counts are unchanged from the unperturbed run.

Source files
------------

// File: rtl/cur_block_fetch.sv
// cur_block_fetch: streams a frame from SRAM into the current-block buffer, one 8x8 block at a time
module cur_block_fetch #(
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              consumer_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       cur_data,
    output logic              read_en,
    output logic              next_block,
    output logic [7:0]        block_x,
    output logic [7:0]        block_y,
    output logic              busy,
    output logic              done
);
    localparam logic [7:0]        BX_MAX    = 8'(FRAME_W / 8 - 1);
    localparam logic [7:0]        BY_MAX    = 8'(FRAME_H / 8 - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(FRAME_W / 4 - 1);
    localparam logic [ADDR_W-1:0] BAND_STEP = ADDR_W'(2 * FRAME_W);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_FETCH, S_DRAIN, S_SWAP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [7:0]        r_bx;
    logic [7:0]        r_by;
    logic [ADDR_W-1:0] r_band;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_d1;
    logic              r_read_en;
    logic [31:0]       r_cur_data;
    logic              w_last;

    assign w_last     = (r_bx == BX_MAX) && (r_by == BY_MAX);
    assign mem_addr   = r_addr;
    assign cur_data   = r_cur_data;
    assign read_en    = r_read_en;
    assign block_x    = r_bx;
    assign block_y    = r_by;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and state-decoded strobes
    always_comb begin
        w_next     = r_state;
        mem_rd     = 1'b0;
        next_block = 1'b0;
        done       = 1'b0;
        busy       = r_state != S_IDLE;
        case (r_state)
            S_IDLE:  w_next = start ? S_WAIT : S_IDLE;
            S_WAIT:  w_next = consumer_ready ? S_FETCH : S_WAIT;
            S_FETCH: begin
                mem_rd = 1'b1;
                w_next = (r_cnt == 4'd15) ? S_DRAIN : S_FETCH;
            end
            S_DRAIN: w_next = r_cnt[0] ? S_SWAP : S_DRAIN;
            S_SWAP: begin
                next_block = 1'b1;
                done       = w_last;
                w_next     = w_last ? S_IDLE : S_WAIT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Word/drain counter, block position and incremental address generation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 4'd0;
            r_bx   <= 8'd0;
            r_by   <= 8'd0;
            r_band <= '0;
            r_addr <= '0;
        end else begin
            r_cnt <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
            if (r_state == S_IDLE && start) begin
                r_bx   <= 8'd0;
                r_by   <= 8'd0;
                r_band <= '0;
            end
            if (r_state == S_SWAP && !w_last) begin
                if (r_bx == BX_MAX) begin
                    r_bx   <= 8'd0;
                    r_by   <= r_by + 8'd1;
                    r_band <= r_band + BAND_STEP;
                end else begin
                    r_bx <= r_bx + 8'd1;
                end
            end
            if (r_state == S_WAIT)
                r_addr <= r_band + ADDR_W'({r_bx, 1'b0});
            else if (r_state == S_FETCH)
                r_addr <= r_cnt[0] ? r_addr + ROW_STEP : r_addr + ONE;
        end
    end

    // Read pipeline: strobe follows mem_rd by two cycles, data captured one cycle after the read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_d1    <= 1'b0;
            r_read_en  <= 1'b0;
            r_cur_data <= 32'd0;
        end else begin
            r_rd_d1   <= mem_rd;
            r_read_en <= r_rd_d1;
            if (r_rd_d1) r_cur_data <= mem_rdata;
        end
    end
endmodule
